// File: rtl/addr_gen_counter.sv
// Programmable base/limit/stride address generator.
// Valid/ready output, one-shot or wrap passes, done/last/abort.
module addr_gen_counter #(
  parameter int CNT_WIDTH    = 7,
  parameter int STRIDE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    mode_i,
  input  logic [CNT_WIDTH-1:0]    base_i,
  input  logic [CNT_WIDTH-1:0]    limit_i,
  input  logic [STRIDE_WIDTH-1:0] stride_i,
  input  logic                    ready_i,
  output logic [CNT_WIDTH-1:0]    cnt_o,
  output logic                    valid_o,
  output logic                    last_o,
  output logic                    done_o,
  output logic                    busy_o
);

  // one extra bit so address + stride never wraps
  localparam int SW = CNT_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_n;

  logic                    mode, mode_n;
  logic [CNT_WIDTH-1:0]    base, base_n;
  logic [CNT_WIDTH-1:0]    limit, limit_n;
  logic [STRIDE_WIDTH-1:0] stride, stride_n;

  logic [CNT_WIDTH-1:0]    cnt, cnt_n;
  logic                    valid, valid_n;
  logic                    last, last_n;
  logic                    done, done_n;
  logic                    busy, busy_n;

  logic                    beat;
  logic [STRIDE_WIDTH-1:0] stride_in;
  logic [SW-1:0]           start_sum;
  logic                    start_last;
  logic [SW-1:0]           step_sum;
  logic [CNT_WIDTH-1:0]    step;
  logic [SW-1:0]           next_sum;
  logic                    next_last;
  logic [SW-1:0]           rewind_sum;
  logic                    rewind_last;

  assign beat = valid & ready_i;

  // a zero stride would never advance, so it runs as one
  assign stride_in = (stride_i == '0) ?
                     STRIDE_WIDTH'(1) : stride_i;

  // last flag for the first address of a fresh pass
  assign start_sum  = SW'(base_i) + SW'(stride_in);
  assign start_last = start_sum > SW'(limit_i);

  // next address; only used when not last, so it fits
  assign step_sum  = SW'(cnt) + SW'(stride);
  assign step      = step_sum[CNT_WIDTH-1:0];
  assign next_sum  = SW'(step) + SW'(stride);
  assign next_last = next_sum > SW'(limit);

  // last flag when a wrap pass restarts at base
  assign rewind_sum  = SW'(base) + SW'(stride);
  assign rewind_last = rewind_sum > SW'(limit);

  // state, config and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode   <= 1'b0;
      base   <= '0;
      limit  <= '0;
      stride <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      mode   <= mode_n;
      base   <= base_n;
      limit  <= limit_n;
      stride <= stride_n;
      cnt    <= cnt_n;
      valid  <= valid_n;
      last   <= last_n;
      done   <= done_n;
      busy   <= busy_n;
    end
  end

  // next-state and next-output decode
  always_comb begin
    state_n  = state;
    mode_n   = mode;
    base_n   = base;
    limit_n  = limit;
    stride_n = stride;
    cnt_n    = cnt;
    valid_n  = valid;
    last_n   = last;
    done_n   = 1'b0;
    busy_n   = busy;

    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        if (start_i && !stop_i) begin
          state_n  = RUN;
          mode_n   = mode_i;
          base_n   = base_i;
          limit_n  = limit_i;
          stride_n = stride_in;
          cnt_n    = base_i;
          valid_n  = 1'b1;
          last_n   = start_last;
          busy_n   = 1'b1;
        end
      end

      RUN: begin
        unique case (1'b1)
          stop_i: begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
          end
          (!stop_i && beat && !last): begin
            cnt_n  = step;
            last_n = next_last;
          end
          (!stop_i && beat && last && !mode): begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
          (!stop_i && beat && last && mode): begin
            cnt_n  = base;
            last_n = rewind_last;
            done_n = 1'b1;
          end
          default: begin
          end
        endcase
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign cnt_o   = cnt;
  assign valid_o = valid;
  assign last_o  = last;
  assign done_o  = done;
  assign busy_o  = busy;

endmodule

// File: tb/tb_addr_gen_counter.sv
// Randomised bench for addr_gen_counter.
// Expected address lists come from base/limit/stride arithmetic.
module tb_addr_gen_counter;

  localparam int CW = 7;
  localparam int SWD = 4;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           stop_i;
  logic           mode_i;
  logic [CW-1:0]  base_i;
  logic [CW-1:0]  limit_i;
  logic [SWD-1:0] stride_i;
  logic           ready_i;
  logic [CW-1:0]  cnt_o;
  logic           valid_o;
  logic           last_o;
  logic           done_o;
  logic           busy_o;

  int tests_run;
  int tests_failed;
  int exp_q[$];

  addr_gen_counter #(
    .CNT_WIDTH(CW),
    .STRIDE_WIDTH(SWD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .stop_i(stop_i),
    .mode_i(mode_i),
    .base_i(base_i),
    .limit_i(limit_i),
    .stride_i(stride_i),
    .ready_i(ready_i),
    .cnt_o(cnt_o),
    .valid_o(valid_o),
    .last_o(last_o),
    .done_o(done_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addresses of one pass: base, base+s, ... while <= limit
  task automatic build_expected(input int b, input int l,
                                input int s);
    int st;
    int a;
    exp_q.delete();
    st = (s == 0) ? 1 : s;
    if (b > l) begin
      exp_q.push_back(b);
    end else begin
      a = b;
      while (a <= l) begin
        exp_q.push_back(a);
        a = a + st;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int m, input int b,
                        input int l, input int s);
    mode_i   = m[0];
    base_i   = CW'(b);
    limit_i  = CW'(l);
    stride_i = SWD'(s);
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 0; stop_i = 0; mode_i = 0;
    base_i = 0; limit_i = 0; stride_i = 0;
    ready_i = 0;
    repeat (3) step();
    tests_run++;
    if ({cnt_o, valid_o, last_o, done_o, busy_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_init: got %h expected 0",
               {cnt_o, valid_o, last_o, done_o, busy_o});
    end
    rst = 1'b0;
    step();
    // run to 0x10 then stall and reset between edges
    launch(0, 16'h10, 127, 1);
    ready_i = 1'b0;
    step();
    tests_run++;
    if (valid_o !== 1'b1 || int'(cnt_o) !== 16) begin
      tests_failed++;
      $display("FAIL reset_pre: got v=%0b cnt=%0d expected v=1 cnt=16",
               valid_o, cnt_o);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({cnt_o, valid_o, last_o, done_o, busy_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected 0",
               {cnt_o, valid_o, last_o, done_o, busy_o});
    end
    #2 rst = 1'b0;
    repeat (2) begin
      step();
      tests_run++;
      if (valid_o !== 0 || done_o !== 0 || busy_o !== 0) begin
        tests_failed++;
        $display("FAIL reset_idle: got v=%0b d=%0b b=%0b expected 0 0 0",
                 valid_o, done_o, busy_o);
      end
    end
  endtask

  task automatic test_oneshot();
    int tb_b[7] = '{0, 3, 3, 120, 120, 0, 127};
    int tb_l[7] = '{9, 20, 20, 110, 127, 127, 127};
    int tb_s[7] = '{1, 4, 0, 3, 15, 15, 7};
    for (int i = 0; i < 22; i++) begin
      int b, l, s, n, idx, cyc;
      bit full, rdy;
      if (i < 7) begin
        b = tb_b[i]; l = tb_l[i]; s = tb_s[i]; full = 1;
      end else begin
        b = $urandom_range(0, 127);
        l = $urandom_range(0, 127);
        s = $urandom_range(0, 15);
        full = 0;
      end
      build_expected(b, l, s);
      n = exp_q.size();
      launch(0, b, l, s);
      tests_run++;
      if (valid_o !== 1 || busy_o !== 1 || int'(cnt_o) !== b) begin
        tests_failed++;
        $display("FAIL os_latency: got v=%0b b=%0b cnt=%0d expected 1 1 %0d",
                 valid_o, busy_o, cnt_o, b);
      end
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 2000) begin
        tests_run++;
        if (valid_o !== 1 || busy_o !== 1 || done_o !== 0) begin
          tests_failed++;
          $display("FAIL os_flags: got v=%0b b=%0b d=%0b expected 1 1 0",
                   valid_o, busy_o, done_o);
        end
        tests_run++;
        if (int'(cnt_o) !== exp_q[idx] ||
            last_o !== (idx == n - 1)) begin
          tests_failed++;
          $display("FAIL os_addr: got cnt=%0d last=%0b expected cnt=%0d last=%0b",
                   cnt_o, last_o, exp_q[idx], idx == n - 1);
        end
        rdy = full ? 1'b1 : ($urandom_range(0, 3) != 0);
        ready_i = rdy;
        // config and start noise while busy must be ignored
        start_i  = ($urandom_range(0, 3) == 0);
        mode_i   = 1'($urandom);
        base_i   = CW'($urandom);
        limit_i  = CW'($urandom);
        stride_i = SWD'($urandom);
        if (rdy) idx++;
        step();
        cyc++;
      end
      start_i = 1'b0;
      ready_i = 1'b0;
      tests_run++;
      if (cyc >= 2000 || (full && cyc !== n)) begin
        tests_failed++;
        $display("FAIL os_cycles: got %0d expected %0d", cyc, n);
      end
      tests_run++;
      if (done_o !== 1 || valid_o !== 0 || busy_o !== 0) begin
        tests_failed++;
        $display("FAIL os_done: got d=%0b v=%0b b=%0b expected 1 0 0",
                 done_o, valid_o, busy_o);
      end
      step();
      tests_run++;
      if (done_o !== 0 || valid_o !== 0) begin
        tests_failed++;
        $display("FAIL os_done_len: got d=%0b v=%0b expected 0 0",
                 done_o, valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx, cyc, stall, seen5;
    build_expected(0, 9, 1);
    launch(0, 0, 9, 1);
    idx = 0; cyc = 0; stall = 0; seen5 = 0;
    while (idx < 10 && cyc < 100) begin
      tests_run++;
      if (valid_o !== 1 || int'(cnt_o) !== exp_q[idx]) begin
        tests_failed++;
        $display("FAIL bp_addr: got v=%0b cnt=%0d expected v=1 cnt=%0d",
                 valid_o, cnt_o, exp_q[idx]);
      end
      if (int'(cnt_o) == 5) seen5++;
      if (int'(cnt_o) == 5 && stall < 3) begin
        ready_i = 1'b0;
        stall++;
      end else begin
        ready_i = 1'b1;
        idx++;
      end
      step();
      cyc++;
    end
    ready_i = 1'b0;
    tests_run++;
    if (seen5 !== 4 || cyc !== 13 || idx !== 10) begin
      tests_failed++;
      $display("FAIL bp_hold: got held=%0d cycles=%0d beats=%0d expected 4 13 10",
               seen5, cyc, idx);
    end
    tests_run++;
    if (done_o !== 1 || busy_o !== 0) begin
      tests_failed++;
      $display("FAIL bp_done: got d=%0b b=%0b expected 1 0",
               done_o, busy_o);
    end
    step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      int b, l, s, n, idx, cyc;
      bit rdy, pend;
      if (i == 0) begin
        b = 2; l = 4; s = 1;
      end else begin
        b = $urandom_range(0, 60);
        l = $urandom_range(0, 127);
        s = $urandom_range(0, 15);
      end
      build_expected(b, l, s);
      n = exp_q.size();
      launch(1, b, l, s);
      idx = 0; cyc = 0; pend = 0;
      while (idx < 3 * n + 1 && cyc < 3000) begin
        tests_run++;
        if (valid_o !== 1 || busy_o !== 1 || done_o !== pend) begin
          tests_failed++;
          $display("FAIL wrap_flags: got v=%0b b=%0b d=%0b expected 1 1 %0b",
                   valid_o, busy_o, done_o, pend);
        end
        tests_run++;
        if (int'(cnt_o) !== exp_q[idx % n] ||
            last_o !== ((idx % n) == n - 1)) begin
          tests_failed++;
          $display("FAIL wrap_addr: got cnt=%0d last=%0b expected cnt=%0d last=%0b",
                   cnt_o, last_o, exp_q[idx % n], (idx % n) == n - 1);
        end
        rdy = (i == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        ready_i = rdy;
        pend = rdy && ((idx % n) == n - 1);
        if (rdy) idx++;
        step();
        cyc++;
      end
      tests_run++;
      if (cyc >= 3000 || (i == 0 && cyc !== 10)) begin
        tests_failed++;
        $display("FAIL wrap_cycles: got %0d expected %0d", cyc, 3 * n + 1);
      end
      tests_run++;
      if (done_o !== pend || valid_o !== 1) begin
        tests_failed++;
        $display("FAIL wrap_tail: got d=%0b v=%0b expected %0b 1",
                 done_o, valid_o, pend);
      end
      stop_i  = 1'b1;
      ready_i = 1'b1;
      step();
      stop_i  = 1'b0;
      ready_i = 1'b0;
      tests_run++;
      if ({valid_o, busy_o, last_o, done_o} !== 4'b0) begin
        tests_failed++;
        $display("FAIL wrap_stop: got %b expected 0000",
                 {valid_o, busy_o, last_o, done_o});
      end
    end
  endtask

  task automatic test_abort();
    int cyc;
    launch(0, 0, 20, 2);
    ready_i = 1'b1;
    cyc = 0;
    while (int'(cnt_o) != 6 && cyc < 50) begin
      step();
      cyc++;
    end
    tests_run++;
    if (cyc !== 3 || valid_o !== 1) begin
      tests_failed++;
      $display("FAIL abort_reach: got cycles=%0d v=%0b expected 3 1",
               cyc, valid_o);
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    tests_run++;
    if ({valid_o, busy_o, last_o, done_o} !== 4'b0) begin
      tests_failed++;
      $display("FAIL abort_stop: got %b expected 0000",
               {valid_o, busy_o, last_o, done_o});
    end
    repeat (3) begin
      step();
      tests_run++;
      if (done_o !== 0 || valid_o !== 0) begin
        tests_failed++;
        $display("FAIL abort_nodone: got d=%0b v=%0b expected 0 0",
                 done_o, valid_o);
      end
    end
    // stop beats the done of a final beat
    launch(0, 5, 5, 1);
    tests_run++;
    if (last_o !== 1 || valid_o !== 1) begin
      tests_failed++;
      $display("FAIL abort_last: got l=%0b v=%0b expected 1 1",
               last_o, valid_o);
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    tests_run++;
    if (done_o !== 0 || valid_o !== 0) begin
      tests_failed++;
      $display("FAIL abort_prio: got d=%0b v=%0b expected 0 0",
               done_o, valid_o);
    end
    // stop beats start in idle
    stop_i = 1'b1;
    launch(0, 1, 9, 1);
    stop_i = 1'b0;
    tests_run++;
    if (valid_o !== 0 || busy_o !== 0) begin
      tests_failed++;
      $display("FAIL abort_start: got v=%0b b=%0b expected 0 0",
               valid_o, busy_o);
    end
    ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    launch(0, 1, 3, 1);
    ready_i = 1'b1;
    repeat (3) step();
    tests_run++;
    if (done_o !== 1 || valid_o !== 0) begin
      tests_failed++;
      $display("FAIL b2b_done: got d=%0b v=%0b expected 1 0",
               done_o, valid_o);
    end
    ready_i = 1'b0;
    launch(0, 7, 8, 1);
    tests_run++;
    if (valid_o !== 1 || busy_o !== 1 || int'(cnt_o) !== 7 ||
        done_o !== 0) begin
      tests_failed++;
      $display("FAIL b2b_start: got v=%0b b=%0b cnt=%0d d=%0b expected 1 1 7 0",
               valid_o, busy_o, cnt_o, done_o);
    end
    ready_i = 1'b1;
    repeat (2) step();
    ready_i = 1'b0;
    tests_run++;
    if (done_o !== 1 || int'(cnt_o) !== 8) begin
      tests_failed++;
      $display("FAIL b2b_end: got d=%0b cnt=%0d expected 1 8",
               done_o, cnt_o);
    end
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_oneshot();
    test_backpressure();
    test_wrap();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
